// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - multiplexed seven-segment display receiver and BCD-to-binary converter
//
// Purpose: watches the active-low segment/anode lines of a four-digit
// multiplexed display, waits for each digit dwell to settle, decodes the
// segment pattern back to a digit code, and once all four positions have been
// seen converts the frame to a 14-bit binary number.
//
// Ports:
//   clock       in   1   rising-edge clock
//   reset       in   1   synchronous active-high reset
//   seg         in   7   segment lines, active-low, bit0=a .. bit6=g
//   an          in   4   anode enables, active-low, an[0]=ones .. an[3]=thousands
//   ones        out  4   last captured ones code
//   tens        out  4   last captured tens code
//   hundreds    out  4   last captured hundreds code
//   thousands   out  4   last captured thousands code
//   number      out  14  binary value of the last good frame
//   valid       out  1   one-cycle pulse when number updates
//   frame_error out  1   one-cycle pulse when a completed frame has a non-numeric digit
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic [13:0] number,
  output logic        valid,
  output logic        frame_error
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] C_CAP = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  logic [6:0]       r_seg_s, r_seg_d;
  logic [3:0]       r_an_s, r_an_d;
  logic [CW-1:0]    r_cnt;
  logic [3:0][3:0]  r_dig;
  logic [3:0][3:0]  r_snap;
  logic [3:0]       r_mask;
  logic [13:0]      r_acc;
  logic [1:0]       r_idx;
  state_t           r_state;
  logic [13:0]      r_number;
  logic             r_valid;
  logic             r_ferr;

  logic             w_chg;
  logic             w_legal;
  logic [1:0]       w_sel;
  logic             w_cap;
  logic [3:0]       w_code;
  logic             w_any_bad;
  state_t           w_state_nxt;
  logic             w_start;
  logic             w_ferr;
  logic             w_mask_clr;

  assign w_chg = {r_seg_s, r_an_s} != {r_seg_d, r_an_d};

  always_comb begin
    w_legal = 1'b1;
    w_sel   = 2'd0;
    case (r_an_s)
      4'b1110: w_sel = 2'd0;
      4'b1101: w_sel = 2'd1;
      4'b1011: w_sel = 2'd2;
      4'b0111: w_sel = 2'd3;
      default: w_legal = 1'b0;
    endcase
  end

  // The counter saturates at STABLE_CYCLES, so it passes STABLE_CYCLES-1
  // exactly once per dwell and each dwell yields a single capture.
  assign w_cap = !w_chg && (r_cnt == C_CAP) && w_legal;

  always_comb begin
    case (r_seg_s)
      7'b1000000: w_code = 4'd0;
      7'b1111001: w_code = 4'd1;
      7'b0100100: w_code = 4'd2;
      7'b0110000: w_code = 4'd3;
      7'b0011001: w_code = 4'd4;
      7'b0010010: w_code = 4'd5;
      7'b0000010: w_code = 4'd6;
      7'b1111000: w_code = 4'd7;
      7'b0000000: w_code = 4'd8;
      7'b0010000: w_code = 4'd9;
      7'b0111111: w_code = 4'hA;
      default:    w_code = 4'hF;
    endcase
  end

  always_comb begin
    w_any_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r_dig[i] > 4'd9) w_any_bad = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ferr      = 1'b0;
    w_mask_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_mask == 4'hF) begin
          w_mask_clr = 1'b1;
          if (w_any_bad) begin
            w_ferr = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = CONV;
          end
        end
      end
      CONV: begin
        if (r_idx == 2'd0) w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seg_s  <= 7'h7F;
      r_seg_d  <= 7'h7F;
      r_an_s   <= 4'hF;
      r_an_d   <= 4'hF;
      r_cnt    <= '0;
      r_dig    <= '0;
      r_snap   <= '0;
      r_mask   <= 4'h0;
      r_acc    <= 14'd0;
      r_idx    <= 2'd0;
      r_state  <= IDLE;
      r_number <= 14'd0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_seg_s <= seg;
      r_an_s  <= an;
      r_seg_d <= r_seg_s;
      r_an_d  <= r_an_s;

      if (w_chg)              r_cnt <= '0;
      else if (r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;

      if (w_cap) r_dig[w_sel] <= w_code;

      // A capture landing on the same edge as the frame-complete clear keeps its bit.
      r_mask <= (w_mask_clr ? 4'h0 : r_mask) | (w_cap ? (4'b0001 << w_sel) : 4'h0);

      r_state <= w_state_nxt;

      if (w_start) begin
        r_snap <= r_dig;
        r_acc  <= 14'd0;
        r_idx  <= 2'd3;
      end else if (r_state == CONV) begin
        r_acc <= (r_acc << 3) + (r_acc << 1) + {10'd0, r_snap[r_idx]};
        r_idx <= r_idx - 2'd1;
      end

      if (r_state == DONE) r_number <= r_acc;
      r_valid <= (r_state == DONE);
      r_ferr  <= w_ferr;
    end
  end

  assign ones        = r_dig[0];
  assign tens        = r_dig[1];
  assign hundreds    = r_dig[2];
  assign thousands   = r_dig[3];
  assign number      = r_number;
  assign valid       = r_valid;
  assign frame_error = r_ferr;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg   = 7'h7F;
  logic [3:0]  an    = 4'hF;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic [13:0] number;
  logic        valid, frame_error;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .number     (number),
    .valid      (valid),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          kind;   // 0 = valid pulse, 1 = frame_error pulse
    logic [13:0] num;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int total = 0;
  int bad   = 0;
  int ones_start = 0;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0:  pat = 7'b1000000;
      1:  pat = 7'b1111001;
      2:  pat = 7'b0100100;
      3:  pat = 7'b0110000;
      4:  pat = 7'b0011001;
      5:  pat = 7'b0010010;
      6:  pat = 7'b0000010;
      7:  pat = 7'b1111000;
      8:  pat = 7'b0000000;
      9:  pat = 7'b0010000;
      10: pat = 7'b0111111;
      default: pat = 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    seg = s;
    an  = a;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic gapf(input int gap);
    if (gap > 0) begin
      hold(pat(8), 4'b1111, gap);
      hold(pat(8), 4'b1100, gap);
    end
  endtask

  // Scans thousands..ones with an 8-cycle dwell each. The ones digit completes
  // the frame: it is captured 6 edges after being driven, frame_error follows
  // one edge later, valid six edges later.
  task automatic scan(input int d3, input int d2, input int d1, input int d0,
                      input int gap, input bit kind, input int num, input bit do_push);
    gapf(gap);
    hold(pat(d3), 4'b0111, 8);
    gapf(gap);
    hold(pat(d2), 4'b1011, 8);
    gapf(gap);
    hold(pat(d1), 4'b1101, 8);
    gapf(gap);
    ones_start = cyc;
    if (do_push) exp_q.push_back('{kind, 14'(num), cyc + (kind ? 7 : 12)});
    hold(pat(d0), 4'b1110, 8);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ones"}, ones, 0);
    check({tag, "_tens"}, tens, 0);
    check({tag, "_hundreds"}, hundreds, 0);
    check({tag, "_thousands"}, thousands, 0);
    check({tag, "_number"}, number, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_frame_error"}, frame_error, 0);
  endtask

  always @(negedge clock) begin
    if (valid || frame_error) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: valid=%0d frame_error=%0d number=%0d at cycle %0d, expected no pulse",
                 valid, frame_error, number, cyc);
      end else begin
        e_mon = exp_q.pop_front();
        check("pulse_kind", frame_error, e_mon.kind);
        check("pulse_valid", valid, !e_mon.kind);
        check("pulse_cycle", cyc, e_mon.at);
        check("pulse_number", number, e_mon.num);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    scan(1, 2, 3, 4, 0, 0, 1234, 1);
    check("d_thousands_1234", thousands, 1);
    check("d_hundreds_1234", hundreds, 2);
    check("d_tens_1234", tens, 3);
    check("d_ones_1234", ones, 4);

    scan(5, 10, 0, 7, 0, 1, 1234, 1);
    check("d_hundreds_dash", hundreds, 10);
    check("d_thousands_5", thousands, 5);

    scan(9, 9, 9, 9, 0, 0, 9999, 1);
    scan(0, 0, 0, 0, 0, 0, 0, 1);

    scan(2, 4, 6, 8, 20, 0, 2468, 1);
    check("d_thousands_2468", thousands, 2);
    check("d_ones_2468", ones, 8);

    hold(pat(1), 4'b0111, 3);
    hold(7'h7F, 4'b1111, 8);
    hold(pat(3), 4'b1011, 8);
    hold(pat(5), 4'b1101, 8);
    hold(pat(7), 4'b1110, 8);
    hold(7'h7F, 4'b1111, 10);
    check("glitch_thousands_kept", thousands, 2);
    exp_q.push_back('{1'b1, 14'd2468, cyc + 7});
    hold(7'b1010101, 4'b0111, 8);
    check("bad_pattern_code", thousands, 15);

    scan(5, 6, 7, 8, 0, 0, 0, 0);
    seg   = 7'h7F;
    an    = 4'hF;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_zero("midconv_reset");
    hold(7'h7F, 4'b1111, 20);

    scan(0, 0, 4, 2, 0, 0, 42, 1);
    hold(7'h7F, 4'b1111, 20);
    check("final_number", number, 42);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
